// File: rtl/inv_f5_stream_pkg.sv
// Shared DSP definitions for the inverse F_5 stream decoder.
//   W_DEFAULT     default sample/coefficient width (two's complement)
//   state_t       decoder FSM states
//   IDX_O0..O3    position of each coefficient within a serial group
package dsp_pkg;

  localparam int unsigned W_DEFAULT = 12;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CALC    = 2'd1,
    OUT     = 2'd2
  } state_t;

  localparam logic [1:0] IDX_O0 = 2'd0;
  localparam logic [1:0] IDX_O1 = 2'd1;
  localparam logic [1:0] IDX_O2 = 2'd2;
  localparam logic [1:0] IDX_O3 = 2'd3;

endpackage

// File: rtl/inv_f5_stream_if.sv
// Stream bundle for inv_f5_stream.
//   IN_DATA/IN_VALID/IN_READY         serial coefficient stream (O0..O3)
//   OUT_I0..OUT_I3/OUT_VALID/OUT_READY parallel reconstructed-sample stream
// slave  : the decoder side
// master : the coefficient source / sample sink side
interface inv_f5_stream_if #(
  parameter int unsigned W = dsp_pkg::W_DEFAULT
);

  logic [W-1:0] IN_DATA;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] OUT_I0;
  logic [W-1:0] OUT_I1;
  logic [W-1:0] OUT_I2;
  logic [W-1:0] OUT_I3;
  logic         OUT_VALID;
  logic         OUT_READY;

  modport slave (
    input  IN_DATA, IN_VALID, OUT_READY,
    output IN_READY, OUT_I0, OUT_I1, OUT_I2, OUT_I3, OUT_VALID
  );

  modport master (
    output IN_DATA, IN_VALID, OUT_READY,
    input  IN_READY, OUT_I0, OUT_I1, OUT_I2, OUT_I3, OUT_VALID
  );

endinterface

// File: rtl/inv_f5_stream_butterfly.sv
// Combinational inverse F_5 butterfly core.
//   a, b   in  W+1  a = c0+c2, b = c0-c2 (signed)
//   c1, c3 in  W    coefficients O1, O3 (signed)
//   i0..i3 out W    reconstructed samples, truncated mod 2^W
// h = a>>>1, g = b>>>1; I0 = h+c1, I2 = h-c1, I1 = g+c3, I3 = g-c3.
module inv_butterfly #(
  parameter int unsigned W = dsp_pkg::W_DEFAULT
) (
  input  logic signed [W:0]   a,
  input  logic signed [W:0]   b,
  input  logic signed [W-1:0] c1,
  input  logic signed [W-1:0] c3,
  output logic        [W-1:0] i0,
  output logic        [W-1:0] i1,
  output logic        [W-1:0] i2,
  output logic        [W-1:0] i3
);

  logic signed [W:0] h;
  logic signed [W:0] g;
  logic signed [W:0] c1x;
  logic signed [W:0] c3x;
  logic        [W:0] s0;
  logic        [W:0] s1;
  logic        [W:0] s2;
  logic        [W:0] s3;

  always_comb begin
    h   = a >>> 1;
    g   = b >>> 1;
    c1x = {c1[W-1], c1};
    c3x = {c3[W-1], c3};
    s0  = h + c1x;
    s2  = h - c1x;
    s1  = g + c3x;
    s3  = g - c3x;
    i0  = s0[W-1:0];
    i1  = s1[W-1:0];
    i2  = s2[W-1:0];
    i3  = s3[W-1:0];
  end

endmodule

// File: rtl/inv_f5_stream.sv
// Inverse 4-point F_5 averaging butterfly on valid/ready streams.
//   CLK    in   clock, posedge
//   RESET  in   synchronous, active-high
//   bus    slave modport: serial coefficients in, parallel samples out
//   BUSY   out  high unless idle in COLLECT with no partial group held
// Collects O0..O3 over four accepted beats, spends one CALC cycle, then
// presents I0..I3 in OUT until the sink takes them.
module inv_f5_stream
  import dsp_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           CLK,
  input  logic           RESET,
  inv_f5_stream_if.slave bus,
  output logic           BUSY
);

  state_t            state;
  state_t            state_next;
  logic [1:0]        idx;
  logic [W-1:0]      c [4];
  logic signed [W:0] a_r;
  logic signed [W:0] b_r;
  logic [W-1:0]      out_i0;
  logic [W-1:0]      out_i1;
  logic [W-1:0]      out_i2;
  logic [W-1:0]      out_i3;
  logic [W-1:0]      bf_i0;
  logic [W-1:0]      bf_i1;
  logic [W-1:0]      bf_i2;
  logic [W-1:0]      bf_i3;
  logic              accept;

  always_comb begin
    state_next    = state;
    bus.IN_READY  = 1'b0;
    bus.OUT_VALID = 1'b0;
    unique case (state)
      COLLECT: begin
        bus.IN_READY = 1'b1;
        if (bus.IN_VALID && idx == IDX_O3) state_next = CALC;
      end
      CALC: state_next = OUT;
      OUT: begin
        bus.OUT_VALID = 1'b1;
        if (bus.OUT_READY) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
    accept = bus.IN_VALID && bus.IN_READY;
    BUSY   = !(state == COLLECT && idx == IDX_O0);
  end

  inv_butterfly #(.W(W)) u_bf (
    .a  (a_r),
    .b  (b_r),
    .c1 (c[IDX_O1]),
    .c3 (c[IDX_O3]),
    .i0 (bf_i0),
    .i1 (bf_i1),
    .i2 (bf_i2),
    .i3 (bf_i3)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= COLLECT;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      out_i0 <= '0;
      out_i1 <= '0;
      out_i2 <= '0;
      out_i3 <= '0;
      for (int unsigned i = 0; i < 4; i++) c[i] <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        c[idx] <= bus.IN_DATA;
        idx    <= idx + 2'd1;
        // c0 and c2 are already held when O3 arrives, so a/b are registered
        // on the O3 edge; CALC then loads the output registers, giving the
        // two-cycle latency with a,b stable going into the butterfly.
        if (idx == IDX_O3) begin
          a_r <= {c[IDX_O0][W-1], c[IDX_O0]} + {c[IDX_O2][W-1], c[IDX_O2]};
          b_r <= {c[IDX_O0][W-1], c[IDX_O0]} - {c[IDX_O2][W-1], c[IDX_O2]};
        end
      end
      if (state == CALC) begin
        out_i0 <= bf_i0;
        out_i1 <= bf_i1;
        out_i2 <= bf_i2;
        out_i3 <= bf_i3;
      end
    end
  end

  assign bus.OUT_I0 = out_i0;
  assign bus.OUT_I1 = out_i1;
  assign bus.OUT_I2 = out_i2;
  assign bus.OUT_I3 = out_i3;

endmodule
